// File: rtl/draw_pkg.sv
// Types and helpers shared by the draw_* sprite pipeline.
package draw_pkg;

  localparam int CW      = 10;
  localparam int COLW    = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    GRANT  = 2'd2,
    GAP    = 2'd3
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of pending at or after rr_ptr, wrapping.
module rr_pick
  import draw_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW:0] cand [N];

  // cand[k] = (rr_ptr + k) mod N without a divider, so N need not be a power of two
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum      = {1'b0, rr_ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
    end
  endgenerate

  // Scan farthest-first so the candidate closest to rr_ptr wins.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pending[cand[k][IW-1:0]]) begin
        index = cand[k][IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame round-robin owner of the VGA write port among N_REQ sprite drawers, with watchdog.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 2048,
  parameter int CW      = draw_pkg::CW,
  parameter int COLW    = draw_pkg::COLW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      done,
  input  logic [N_REQ*CW-1:0]   in_x,
  input  logic [N_REQ*CW-1:0]   in_y,
  input  logic [N_REQ*COLW-1:0] in_color,
  input  logic [N_REQ-1:0]      in_plot,
  output logic [N_REQ-1:0]      grant,
  output logic [CW-1:0]         vga_x,
  output logic [CW-1:0]         vga_y,
  output logic [COLW-1:0]       vga_color,
  output logic                  vga_plot,
  output logic                  frame_busy,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]    cur_reg, cur_next;
  logic [WW-1:0]    wd_cnt_reg, wd_cnt_next;
  logic             frame_busy_reg, frame_busy_next;
  logic             overrun_reg, overrun_next;
  logic             timeout_reg, timeout_next;
  logic [CW-1:0]    vga_x_reg, vga_x_next, vga_y_reg, vga_y_next;
  logic [COLW-1:0]  vga_color_reg, vga_color_next;
  logic             vga_plot_reg, vga_plot_next;

  logic [CW-1:0]    x_arr [N_REQ];
  logic [CW-1:0]    y_arr [N_REQ];
  logic [COLW-1:0]  c_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign x_arr[gi] = in_x[gi*CW +: CW];
      assign y_arr[gi] = in_y[gi*CW +: CW];
      assign c_arr[gi] = in_color[gi*COLW +: COLW];
    end
  endgenerate

  // A drawer that dropped req before its turn is skipped rather than granted.
  logic [N_REQ-1:0]   live;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [MAX_REQ-1:0] pick_oh;
  logic               finish, wd_expire;

  assign live      = pending_reg & req;
  assign pick_oh   = onehot(3'(pick_idx));
  assign finish    = done[cur_reg] | ~req[cur_reg];
  assign wd_expire = (wd_cnt_reg == WW'(TIMEOUT - 1));

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .pending (live),
    .rr_ptr  (rr_ptr_reg),
    .index   (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    cur_next        = cur_reg;
    wd_cnt_next     = wd_cnt_reg;
    frame_busy_next = frame_busy_reg;
    overrun_next    = overrun_reg;
    timeout_next    = timeout_reg;
    vga_x_next      = vga_x_reg;
    vga_y_next      = vga_y_reg;
    vga_color_next  = vga_color_reg;
    vga_plot_next   = 1'b0;

    if (frame_tick && state_reg != IDLE) overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          pending_next    = req;
          frame_busy_next = 1'b1;
          state_next      = SEARCH;
        end
      end
      SEARCH: begin
        pending_next = live;
        if (pick_valid) begin
          grant_next  = pick_oh[N_REQ-1:0];
          cur_next    = pick_idx;
          wd_cnt_next = '0;
          state_next  = GRANT;
        end else begin
          frame_busy_next = 1'b0;
          state_next      = IDLE;
        end
      end
      GRANT: begin
        vga_x_next     = x_arr[cur_reg];
        vga_y_next     = y_arr[cur_reg];
        vga_color_next = c_arr[cur_reg];
        vga_plot_next  = in_plot[cur_reg];
        if (wd_cnt_reg != '1) wd_cnt_next = wd_cnt_reg + WW'(1);
        // done wins over a simultaneous watchdog expiry
        if (finish || wd_expire) begin
          if (!finish) timeout_next = 1'b1;
          pending_next[cur_reg] = 1'b0;
          rr_ptr_next = (cur_reg == IW'(N_REQ - 1)) ? '0 : cur_reg + IW'(1);
          grant_next  = '0;
          state_next  = GAP;
        end
      end
      GAP:     state_next = SEARCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      cur_reg        <= '0;
      wd_cnt_reg     <= '0;
      frame_busy_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_color_reg  <= '0;
      vga_plot_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      cur_reg        <= cur_next;
      wd_cnt_reg     <= wd_cnt_next;
      frame_busy_reg <= frame_busy_next;
      overrun_reg    <= overrun_next;
      timeout_reg    <= timeout_next;
      vga_x_reg      <= vga_x_next;
      vga_y_reg      <= vga_y_next;
      vga_color_reg  <= vga_color_next;
      vga_plot_reg   <= vga_plot_next;
    end
  end

  assign grant      = grant_reg;
  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_color  = vga_color_reg;
  assign vga_plot   = vga_plot_reg;
  assign frame_busy = frame_busy_reg;
  assign overrun    = overrun_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: ordering, muxing, watchdog, overrun and reset.
module tb_draw_scheduler;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int COLW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_tick;
  logic [N-1:0]      req, done, in_plot, grant;
  logic [N*CW-1:0]   in_x, in_y;
  logic [N*COLW-1:0] in_color;
  logic [CW-1:0]     vga_x, vga_y;
  logic [COLW-1:0]   vga_color;
  logic              vga_plot, frame_busy, overrun, timeout;

  int vectors     = 0;
  int miscompares = 0;

  draw_scheduler #(.N_REQ(N), .TIMEOUT(16), .CW(CW), .COLW(COLW)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .req        (req),
    .done       (done),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .in_plot    (in_plot),
    .grant      (grant),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_plot   (vga_plot),
    .frame_busy (frame_busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global time limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, then check who got it and how many cycles it took.
  task automatic await_grant(input logic [N-1:0] exp, input int exp_wait, input string tag);
    int n;
    n = 0;
    while (grant === '0 && n < 40) begin
      step();
      n++;
    end
    check({tag, " grant"}, 32'(grant), 32'(exp));
    check({tag, " latency"}, 32'(n), 32'(exp_wait));
  endtask

  // Granted drawer holds for `hold` cycles, pulses done and drops its request.
  task automatic serve(input int idx, input int hold, input string tag);
    repeat (hold - 1) step();
    done[idx] = 1'b1;
    step();
    done    = '0;
    req[idx] = 1'b0;
    check({tag, " grant released"}, 32'(grant), 32'(0));
  endtask

  task automatic tick(input logic [N-1:0] r);
    req        = r;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; req = '0; done = '0;
    in_plot = '0; in_x = '0; in_y = '0; in_color = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset grant", 32'(grant), 32'(0));
    check("reset vga_plot", 32'(vga_plot), 32'(0));
    check("reset vga_x", 32'(vga_x), 32'(0));
    check("reset frame_busy", 32'(frame_busy), 32'(0));
    check("reset overrun", 32'(overrun), 32'(0));
    check("reset timeout", 32'(timeout), 32'(0));
    $display("reset checked");

    // Frame A: req=1011 from rr_ptr=0
    tick(4'b1011);
    check("A busy", 32'(frame_busy), 32'(1));
    await_grant(4'b0001, 1, "A0"); serve(0, 10, "A0");
    await_grant(4'b0010, 2, "A1"); serve(1, 10, "A1");
    await_grant(4'b1000, 2, "A3"); serve(3, 10, "A3");
    step();
    check("A busy in search", 32'(frame_busy), 32'(1));
    step();
    check("A busy end", 32'(frame_busy), 32'(0));
    $display("frame A done");

    // Frame B: rr_ptr back to 0; drawer 1's pixel must win over drawer 0's
    in_x[0 +: CW] = 10'd7;
    tick(4'b0011);
    await_grant(4'b0001, 1, "B0"); serve(0, 4, "B0");
    check("B vga_x from drawer0", 32'(vga_x), 32'(7));
    in_plot = 4'b0011;
    in_x[CW +: CW]       = 10'd100;
    in_y[CW +: CW]       = 10'd50;
    in_color[COLW +: COLW] = 3'b101;
    step();
    check("B gap vga_plot", 32'(vga_plot), 32'(0));
    check("B gap vga_x held", 32'(vga_x), 32'(7));
    await_grant(4'b0010, 1, "B1");
    check("B plot before mux", 32'(vga_plot), 32'(0));
    step();
    check("B mux vga_x", 32'(vga_x), 32'(100));
    check("B mux vga_y", 32'(vga_y), 32'(50));
    check("B mux vga_color", 32'(vga_color), 32'(3'b101));
    check("B mux vga_plot", 32'(vga_plot), 32'(1));
    serve(1, 5, "B1");
    check("B last pixel plot", 32'(vga_plot), 32'(1));
    in_plot = '0;
    step();
    check("B gap after plot", 32'(vga_plot), 32'(0));
    check("B vga_x hold", 32'(vga_x), 32'(100));
    step();
    check("B busy end", 32'(frame_busy), 32'(0));
    $display("frame B done");

    // Frame C: req=1111 from rr_ptr=2
    tick(4'b1111);
    await_grant(4'b0100, 1, "C2"); serve(2, 3, "C2");
    await_grant(4'b1000, 2, "C3"); serve(3, 3, "C3");
    await_grant(4'b0001, 2, "C0"); serve(0, 3, "C0");
    await_grant(4'b0010, 2, "C1"); serve(1, 3, "C1");
    step(); step();
    check("C busy end", 32'(frame_busy), 32'(0));
    $display("frame C done");

    // Frame D: drawer 2 hangs; an extra tick arrives mid-grant with req[3] raised
    tick(4'b0101);
    await_grant(4'b0100, 1, "D2");
    repeat (3) step();
    req[3] = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    req[3] = 1'b0;
    check("D overrun set", 32'(overrun), 32'(1));
    check("D grant undisturbed", 32'(grant), 32'(4'b0100));
    check("D busy during overrun", 32'(frame_busy), 32'(1));
    repeat (11) step();
    check("D grant at cycle 16", 32'(grant), 32'(4'b0100));
    check("D timeout not yet", 32'(timeout), 32'(0));
    step();
    check("D grant revoked", 32'(grant), 32'(0));
    check("D timeout set", 32'(timeout), 32'(1));
    await_grant(4'b0001, 2, "D0"); serve(0, 3, "D0");
    req = '0;
    step(); step();
    check("D busy end", 32'(frame_busy), 32'(0));
    check("D timeout sticky", 32'(timeout), 32'(1));
    $display("frame D done");

    // Frame E: reset in the middle of a grant
    tick(4'b1111);
    await_grant(4'b0010, 1, "E1");
    in_plot = 4'b0010;
    step();
    check("E plot before reset", 32'(vga_plot), 32'(1));
    check("E overrun sticky", 32'(overrun), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0; in_plot = '0; req = '0;
    check("E reset grant", 32'(grant), 32'(0));
    check("E reset vga_plot", 32'(vga_plot), 32'(0));
    check("E reset busy", 32'(frame_busy), 32'(0));
    check("E reset overrun", 32'(overrun), 32'(0));
    check("E reset timeout", 32'(timeout), 32'(0));
    check("E reset vga_x", 32'(vga_x), 32'(0));
    $display("frame E done");

    // Frame F: tick with no requests -> brief busy, no grant
    tick(4'b0000);
    check("F busy", 32'(frame_busy), 32'(1));
    step();
    check("F busy end", 32'(frame_busy), 32'(0));
    check("F no grant", 32'(grant), 32'(0));
    check("F no overrun", 32'(overrun), 32'(0));
    $display("frame F done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
